// File: rtl/cnn_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_frame_sequencer
//  Brief    : Streams one WxW frame from a frame buffer into the CNN pipeline,
//             collects the (W-2)^2 results into a result buffer and reports
//             done / drain timeout as a single frame transaction.
//  Revision : 1.0 - initial release
// ============================================================================
module cnn_frame_sequencer #(
    parameter int W          = 5,
    parameter int ADDR_W     = 5,
    parameter int OUT_ADDR_W = 4,
    parameter int DRAIN_TO   = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  pause,
    output logic                  fb_rd_en,
    output logic [ADDR_W-1:0]     fb_rd_addr,
    input  logic [7:0]            fb_rd_data,
    output logic [7:0]            pixel_in,
    output logic                  pixel_valid,
    input  logic [7:0]            cnn_out,
    input  logic                  cnn_out_valid,
    output logic                  res_wr_en,
    output logic [OUT_ADDR_W-1:0] res_wr_addr,
    output logic [7:0]            res_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout
);

    localparam int                RES_W     = OUT_ADDR_W + 1;
    localparam int                DRAIN_W   = $clog2(DRAIN_TO + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(W * W - 1);
    localparam logic [RES_W-1:0]  NUM_RES   = RES_W'((W - 2) * (W - 2));
    localparam logic [DRAIN_W-1:0] DRAIN_MAX = DRAIN_W'(DRAIN_TO);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       rd_cnt_q, rd_cnt_d;
    logic [RES_W-1:0]        res_cnt_q, res_cnt_d;
    logic [DRAIN_W-1:0]      drain_cnt_q, drain_cnt_d;
    logic                    timeout_q, timeout_d;
    logic                    pixel_valid_q;
    logic                    res_wr_en_q, res_wr_en_d;
    logic [OUT_ADDR_W-1:0]   res_wr_addr_q, res_wr_addr_d;
    logic [7:0]              res_wr_data_q, res_wr_data_d;
    logic                    capture;

    always_comb begin
        state_d       = state_q;
        rd_cnt_d      = rd_cnt_q;
        res_cnt_d     = res_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        timeout_d     = timeout_q;
        fb_rd_en      = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        res_wr_en_d   = 1'b0;
        res_wr_addr_d = '0;
        res_wr_data_d = 8'h00;

        capture = ((state_q == S_STREAM) || (state_q == S_DRAIN)) && cnn_out_valid
                  && (res_cnt_q < NUM_RES) && !abort;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d     = S_STREAM;
                    rd_cnt_d    = '0;
                    res_cnt_d   = '0;
                    drain_cnt_d = '0;
                    timeout_d   = 1'b0;
                end
            end
            S_STREAM: begin
                busy        = 1'b1;
                drain_cnt_d = '0;
                if (!pause && !abort) begin
                    fb_rd_en = 1'b1;
                    // The counter parks on the last address instead of wrapping.
                    if (rd_cnt_q == LAST_ADDR) begin
                        state_d = S_DRAIN;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (capture) begin
                    drain_cnt_d = '0;
                end else if (drain_cnt_q != DRAIN_MAX) begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
                if (res_cnt_q == NUM_RES) begin
                    state_d = S_DONE;
                end else if ((drain_cnt_q == DRAIN_MAX) && !capture) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (capture) begin
            res_wr_en_d   = 1'b1;
            res_wr_addr_d = res_cnt_q[OUT_ADDR_W-1:0];
            res_wr_data_d = cnn_out;
            res_cnt_d     = res_cnt_q + 1'b1;
        end

        // Abort overrides every transition, including a pending timeout.
        if (abort) begin
            state_d   = S_IDLE;
            done      = 1'b0;
            timeout_d = timeout_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rd_cnt_q      <= '0;
            res_cnt_q     <= '0;
            drain_cnt_q   <= '0;
            timeout_q     <= 1'b0;
            pixel_valid_q <= 1'b0;
            res_wr_en_q   <= 1'b0;
            res_wr_addr_q <= '0;
            res_wr_data_q <= 8'h00;
        end else begin
            state_q       <= state_d;
            rd_cnt_q      <= rd_cnt_d;
            res_cnt_q     <= res_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            timeout_q     <= timeout_d;
            pixel_valid_q <= fb_rd_en;
            res_wr_en_q   <= res_wr_en_d;
            res_wr_addr_q <= res_wr_addr_d;
            res_wr_data_q <= res_wr_data_d;
        end
    end

    assign fb_rd_addr  = fb_rd_en ? rd_cnt_q : '0;
    assign pixel_valid = pixel_valid_q;
    assign pixel_in    = pixel_valid_q ? fb_rd_data : 8'h00;
    assign res_wr_en   = res_wr_en_q;
    assign res_wr_addr = res_wr_addr_q;
    assign res_wr_data = res_wr_data_q;
    assign timeout     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_cnn_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cnn_frame_sequencer
//  Brief    : Randomized frame transactions for cnn_frame_sequencer checked
//             against a frame-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cnn_frame_sequencer;

    localparam int W          = 5;
    localparam int ADDR_W     = 5;
    localparam int OUT_ADDR_W = 4;
    localparam int DRAIN_TO   = 64;
    localparam int NPIX       = W * W;
    localparam int NRES       = (W - 2) * (W - 2);

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic                  abort = 1'b0;
    logic                  pause = 1'b0;
    logic                  fb_rd_en;
    logic [ADDR_W-1:0]     fb_rd_addr;
    logic [7:0]            fb_rd_data = 8'h00;
    logic [7:0]            pixel_in;
    logic                  pixel_valid;
    logic [7:0]            cnn_out = 8'h00;
    logic                  cnn_out_valid = 1'b0;
    logic                  res_wr_en;
    logic [OUT_ADDR_W-1:0] res_wr_addr;
    logic [7:0]            res_wr_data;
    logic                  busy;
    logic                  done;
    logic                  timeout;

    cnn_frame_sequencer #(
        .W(W), .ADDR_W(ADDR_W), .OUT_ADDR_W(OUT_ADDR_W), .DRAIN_TO(DRAIN_TO)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pause(pause),
        .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
        .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .cnn_out(cnn_out), .cnn_out_valid(cnn_out_valid),
        .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data),
        .busy(busy), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Synchronous frame buffer model: data one cycle after the read strobe.
    logic [7:0] fb [NPIX];
    always @(posedge clk) if (fb_rd_en) fb_rd_data <= fb[fb_rd_addr];

    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    int              rd_seen, wr_seen, done_cnt, done_cyc, last_rd_cyc, last_cap_cyc, exp_pushed;
    bit              prev_en = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [7:0]      exp_q [$];

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic observe();
        if (fb_rd_en) begin
            check_value("rd_addr", 32'(fb_rd_addr), rd_seen);
            check_value("rd_while_busy", 32'(busy), 1);
            rd_seen++;
            last_rd_cyc = cyc;
        end
        if (pixel_valid || prev_en) check_value("pixel_valid", 32'(pixel_valid), 32'(prev_en));
        if (pixel_valid && prev_en) check_value("pixel_in", 32'(pixel_in), 32'(fb[prev_addr]));
        if (!pixel_valid) check_value("pixel_in_zero", 32'(pixel_in), 0);
        if (res_wr_en) begin
            check_value("wr_addr", 32'(res_wr_addr), wr_seen);
            if (exp_q.size() == 0) check_value("wr_unexpected", 32'(res_wr_en), 0);
            else check_value("wr_data", 32'(res_wr_data), 32'(exp_q.pop_front()));
            wr_seen++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_en   = fb_rd_en;
        prev_addr = fb_rd_addr;
    endtask

    task automatic load_image(input bit test_image);
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++)
                if (!test_image) fb[r*W+c] = 8'($urandom);
                else if (r == 0 || r == W-1 || c == 0 || c == W-1) fb[r*W+c] = 8'd10;
                else if (r == W/2 && c == W/2) fb[r*W+c] = 8'd100;
                else fb[r*W+c] = 8'd50;
    endtask

    // pmode: 0 no pause, 1 random pause, 2 three-cycle pause after address 7.
    task automatic run_frame(input int nres, input int pmode, input int abort_at,
                             input int rst_at, input int restart_at);
        int  gap = $urandom_range(0, 12);
        int  pleft = 0, sent = 0, n = 0, exp_done;
        bit  pdir = 0, ended = 0, aborted = 0, abort_now = 0, restarted = 0, first = 1, broken = 0;
        rd_seen = 0; wr_seen = 0; done_cnt = 0; done_cyc = 0;
        last_rd_cyc = 0; last_cap_cyc = 0; exp_pushed = 0;
        exp_q.delete();

        @(negedge clk); cyc++;
        start = 1'b1; cnn_out_valid = 1'b0; pause = 1'b0;
        #1 observe();
        check_value("idle_not_busy", 32'(busy), 0);

        while (!ended && n < 2000) begin
            @(negedge clk); cyc++; n++;
            start = 1'b0;
            abort = 1'b0;
            if (pmode == 1) pause = ($urandom_range(0, 3) == 0);
            else if (pmode == 2) begin
                if (rd_seen == 8 && !pdir) begin pleft = 3; pdir = 1; end
                pause = (pleft > 0);
                if (pleft > 0) pleft--;
            end else pause = 1'b0;
            cnn_out_valid = 1'b0;
            cnn_out = 8'h00;
            if (sent < nres) begin
                if (gap == 0) begin
                    cnn_out_valid = 1'b1;
                    cnn_out = 8'($urandom);
                    sent++;
                    gap = $urandom_range(0, 12);
                end else gap--;
            end
            if (restart_at >= 0 && rd_seen == restart_at && !restarted) begin
                start = 1'b1; restarted = 1;
            end
            abort_now = (abort_at >= 0 && rd_seen == abort_at && !aborted);
            if (abort_now) begin abort = 1'b1; aborted = 1; end
            #1 observe();
            if (first) begin
                check_value("busy_after_start", 32'(busy), 1);
                check_value("timeout_cleared", 32'(timeout), 0);
                first = 0;
            end
            if (pause && busy) check_value("pause_no_read", 32'(fb_rd_en), 0);
            if (abort_now) check_value("abort_no_read", 32'(fb_rd_en), 0);
            else if (aborted) begin
                check_value("abort_idle", 32'(busy), 0);
                check_value("abort_no_done", 32'(done), 0);
                ended = 1; broken = 1;
            end
            if (cnn_out_valid && busy && !abort && exp_pushed < NRES) begin
                exp_q.push_back(cnn_out);
                exp_pushed++;
                last_cap_cyc = cyc;
            end
            if (done) ended = 1;
            if (rst_at >= 0 && rd_seen == rst_at && !ended) begin
                #2 rst_n = 1'b0;
                #1 check_value("rst_outputs", 32'({fb_rd_en, fb_rd_addr, pixel_valid, pixel_in,
                    res_wr_en, res_wr_addr, res_wr_data, busy, done, timeout}), 0);
                @(negedge clk); cyc++;
                rst_n = 1'b1;
                prev_en = 1'b0;
                ended = 1; broken = 1;
            end
        end
        check_value("frame_ended", 32'(ended), 1);
        cnn_out_valid = 1'b0; pause = 1'b0; abort = 1'b0; start = 1'b0;
        if (broken) begin
            exp_q.delete();
            check_value("broken_no_done", done_cnt, 0);
        end else begin
            check_value("read_count", rd_seen, NPIX);
            check_value("write_count", wr_seen, exp_pushed);
            check_value("writes_pending", exp_q.size(), 0);
            check_value("timeout_flag", 32'(timeout), 32'(exp_pushed < NRES));
            if (exp_pushed < NRES) begin
                exp_done = ((last_cap_cyc + 1 > last_rd_cyc + 1) ? last_cap_cyc + 1 : last_rd_cyc + 1)
                           + DRAIN_TO + 1;
                check_value("timeout_latency", done_cyc, exp_done);
            end
            @(negedge clk); cyc++;
            #1 observe();
            check_value("busy_after_done", 32'(busy), 0);
            check_value("done_once", done_cnt, 1);
            check_value("timeout_sticky", 32'(timeout), 32'(exp_pushed < NRES));
        end
    endtask

    task automatic idle_valids(input int count);
        for (int i = 0; i < count; i++) begin
            @(negedge clk); cyc++;
            cnn_out_valid = 1'b1;
            cnn_out = 8'($urandom);
            #1 observe();
            check_value("idle_no_write", 32'(res_wr_en), 0);
            check_value("idle_not_busy", 32'(busy), 0);
        end
        @(negedge clk); cyc++;
        cnn_out_valid = 1'b0;
        #1 observe();
        check_value("idle_no_write", 32'(res_wr_en), 0);
    endtask

    initial begin
        load_image(1'b1);
        repeat (2) @(negedge clk);
        #1 check_value("reset_outputs", 32'({fb_rd_en, fb_rd_addr, pixel_valid, pixel_in,
            res_wr_en, res_wr_addr, res_wr_data, busy, done, timeout}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(NRES, 0, -1, -1, -1);
        load_image(1'b0);
        run_frame(NRES, 2, -1, -1, -1);
        run_frame(NRES - 1, 0, -1, -1, -1);
        run_frame(NRES, 1, -1, -1, -1);
        run_frame(NRES, 0, 12, -1, -1);
        run_frame(NRES, 0, -1, -1, -1);
        run_frame(NRES, 1, -1, 10, -1);
        load_image(1'b0);
        run_frame(NRES, 0, -1, -1, -1);
        run_frame(NRES, 0, -1, -1, 5);
        idle_valids(10);
        for (int k = 0; k < 6; k++) begin
            load_image(1'b0);
            run_frame($urandom_range(NRES - 2, NRES + 3), 1, -1, -1, -1);
        end
        run_frame(NRES, 0, -1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
